// File: rtl/freq_meter_ctrl.sv
// Measurement-window controller: counts synchronised rising edges of sig_in between
// consecutive tick_1s pulses and publishes the saturated count with a valid pulse.
module freq_meter_ctrl #(
  parameter int CNT_W       = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1s,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont_en,
  input  logic             abort,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sig_dly_p1;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic                   sat;
  logic [CNT_W:0]         inc;

  // Returns {saturated_this_cycle, next_value}; the counter sticks at CNT_MAX.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    if (en && (val == CNT_MAX)) return {1'b1, CNT_MAX};
    return {1'b0, val + {{(CNT_W-1){1'b0}}, en}};
  endfunction

  assign rise = sync_p0[SYNC_STAGES-1] & ~sig_dly_p1;
  assign inc  = sat_inc(cnt, rise);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= '0;
      sig_dly_p1 <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // synchroniser stages, then edge-detect delay
      sync_p0    <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      sig_dly_p1 <= sync_p0[SYNC_STAGES-1];
      freq_valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
        sat   <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= ARM;
              busy  <= 1'b1;
            end
          end
          ARM: begin
            // an edge landing on the opening tick belongs to no window
            if (tick_1s) begin
              state <= COUNT;
              cnt   <= '0;
              sat   <= 1'b0;
            end
          end
          COUNT: begin
            if (tick_1s) begin
              freq       <= inc[CNT_W-1:0];
              overflow   <= sat | inc[CNT_W];
              freq_valid <= 1'b1;
              cnt        <= '0;
              sat        <= 1'b0;
              if (!cont_en) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= inc[CNT_W-1:0];
              sat <= sat | inc[CNT_W];
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_ctrl.sv
// Bench for freq_meter_ctrl: a control-vector table, hand-built boundary sequences and
// periodic/random sig_in runs checked against a window/edge-counting reference model.
module tb_freq_meter_ctrl;

  localparam int S    = 2;
  localparam int MAXC = 60000;

  logic        clk, rst, tick_1s, sig_in, start, cont_en, abort;
  logic [26:0] freq;
  logic        freq_valid, overflow, busy;
  logic [3:0]  freq4;
  logic        freq_valid4, overflow4, busy4;

  freq_meter_ctrl dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .sig_in(sig_in), .start(start),
    .cont_en(cont_en), .abort(abort), .freq(freq), .freq_valid(freq_valid),
    .overflow(overflow), .busy(busy)
  );

  freq_meter_ctrl #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .sig_in(sig_in), .start(start),
    .cont_en(cont_en), .abort(abort), .freq(freq4), .freq_valid(freq_valid4),
    .overflow(overflow4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  hist [MAXC];

  // Reference model: 0 idle, 1 waiting for tick, 2 inside a window
  int  m = 0;
  int  open_c = 0;
  longint exp_freq = 0, exp_freq4 = 0;
  bit  exp_ovf = 0, exp_ovf4 = 0, exp_valid = 0;

  function automatic int edges(int o, int c);
    int n = 0;
    for (int k = o - S + 1; k <= c - S; k++)
      if (hist[k] && !hist[k-1]) n++;
    return n;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit tk, input bit ce, input bit sg,
                      input bit rs);
    int n;
    start = st; abort = ab; tick_1s = tk; cont_en = ce; sig_in = sg; rst = rs;
    @(posedge clk);
    cyc++;
    if (cyc < MAXC) hist[cyc] = sg;
    exp_valid = 1'b0;
    if (rs) begin
      m = 0; exp_freq = 0; exp_freq4 = 0; exp_ovf = 0; exp_ovf4 = 0;
    end else if (ab) begin
      m = 0;
    end else if (m == 0) begin
      if (st) m = 1;
    end else if (m == 1) begin
      if (tk) begin m = 2; open_c = cyc; end
    end else if (tk) begin
      n = edges(open_c, cyc);
      exp_freq  = n;
      exp_ovf   = 1'b0;
      exp_freq4 = (n > 15) ? 15 : n;
      exp_ovf4  = (n > 15);
      exp_valid = 1'b1;
      if (ce) open_c = cyc;
      else m = 0;
    end
    #1;
    check("busy", busy, m != 0);
    check("freq_valid", freq_valid, exp_valid);
    check("freq", freq, exp_freq);
    check("overflow", overflow, exp_ovf);
    check("busy4", busy4, m != 0);
    check("freq_valid4", freq_valid4, exp_valid);
    check("freq4", freq4, exp_freq4);
    check("overflow4", overflow4, exp_ovf4);
  endtask

  // per: sig_in period in cycles (periodic mode); rnd: one random bit per cycle
  task automatic run(int n, int tp, int per, bit rnd, bit ce);
    int c;
    bit sg;
    for (int i = 0; i < n; i++) begin
      c  = cyc + 1;
      sg = rnd ? bit'($urandom % 2) : ((c % per) < (per / 2));
      step(0, 0, (c % tp) == 0, ce, sg, 0);
    end
  endtask

  typedef struct {
    bit st, ab, tk, ce;
    bit exp_busy, exp_valid;
    int exp_freq;
  } vec_t;

  vec_t vecs [11];
  bit   bseq [13];

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 1, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 1, 0, 0, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0};
    bseq = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1};

    start = 0; abort = 0; tick_1s = 0; cont_en = 0; sig_in = 0; rst = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    check("reset_freq", freq, 0);
    check("reset_busy", busy, 0);

    // control table: start/abort priority, start while busy, tick in idle
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].st, vecs[i].ab, vecs[i].tk, vecs[i].ce, 0, 0);
      check("tbl_busy", busy, vecs[i].exp_busy);
      check("tbl_valid", freq_valid, vecs[i].exp_valid);
      check("tbl_freq", freq, vecs[i].exp_freq);
    end

    // single shot, period 10 -> 100 edges (saturates the 4-bit counter)
    step(1, 0, 0, 0, 0, 0);
    run(2500, 1000, 10, 0, 0);
    check("single_freq", freq, 100);
    check("single_ovf4", overflow4, 1);
    check("single_freq4", freq4, 15);
    check("single_idle", busy, 0);

    // single shot, period 200 -> 5 edges, clears overflow
    step(1, 0, 0, 0, 0, 0);
    run(2500, 1000, 200, 0, 0);
    check("small_freq4", freq4, 5);
    check("small_ovf4", overflow4, 0);

    // continuous: period 20 then period 8, then stop
    step(1, 0, 0, 0, 0, 0);
    run(3100, 1000, 20, 0, 1);
    run(2000, 1000, 8, 0, 1);
    run(1100, 1000, 8, 0, 0);
    check("cont_freq", freq, 125);
    check("cont_idle", busy, 0);

    // edge on opening tick not counted, edge on closing tick counted
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) step(0, 0, (i == 3) || (i == 12), 0, bseq[i], 0);
    check("boundary_freq", freq, 2);
    step(0, 0, 0, 0, 0, 0);
    check("boundary_valid_low", freq_valid, 0);

    // random sig_in in continuous mode, then random-length aborted windows
    step(1, 0, 0, 0, 0, 0);
    run(3000, 1000, 2, 1, 1);
    run(1200, 1000, 2, 1, 0);
    for (int r = 0; r < 5; r++) begin
      step(1, $urandom % 4 == 0, 0, 0, 0, 0);
      run(100 + int'($urandom % 1400), 1000, 2, 1, $urandom % 2);
      step(0, 1, 0, 0, 0, 0);
    end

    // reset in the middle of a window
    step(1, 0, 0, 0, 0, 0);
    run(1500, 1000, 10, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    check("rst_mid_freq", freq, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", freq_valid, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    run(2100, 1000, 10, 0, 0);
    check("after_rst_freq", freq, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter_ctrl.md
# freq_meter_ctrl

Measurement-window controller for the Lab 7 frequency measurement and control system. It takes the single-cycle 1 Hz window tick from the clock divider and synchronises the external signal under test. It counts rising edges of that signal over exactly one tick-to-tick window and publishes the latched count, with a valid pulse, to the display and control logic. It supports single-shot and continuous (back-to-back, gap-free) measurement, plus an immediate abort.

## Interface
Parameters:
- CNT_W, 27, width of the edge counter and of the result; covers up to 2^27-1 edges per window.
- SYNC_STAGES, 2, number of flops in the sig_in synchroniser; must be ≥ 2.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, synchronous, active-high
- tick_1s  in  1  single-cycle window pulse from the clock divider, once per second
- sig_in  in  1  signal under test; asynchronous to clk
- start  in  1  single-cycle request to begin measuring; ignored unless in IDLE
- cont_en  in  1  level input: 1 = re-arm automatically after each window; 0 = stop after the current window
- abort  in  1  level/pulse input: return to IDLE at once, discarding the window in progress
- freq  out  CNT_W  edge count of the last completed window
- freq_valid  out  1  single-cycle pulse; high when freq has just been updated
- overflow  out  1  set when the last completed window saturated; updated together with freq
- busy  out  1  high in ARM and COUNT

## Operation
- Synchroniser: SYNC_STAGES flops feed a delay flop; edge = synced & ~delayed. All of these flops reset to 0.
- Counter: cleared to 0 when a window opens. Increments by 1 on each cycle with edge=1 while in COUNT. Saturates at 2^CNT_W-1 and sets an internal sat flag; it never wraps.
- States:
  - IDLE: busy=0. start=1 → ARM.
  - ARM: waits for window alignment. tick_1s=1 → COUNT, counter cleared, sat cleared.
  - COUNT, on tick_1s=1 (window close):
    - freq <= saturated(cnt + edge)
    - overflow <= sat, or the increment in this cycle saturates
    - freq_valid <= 1 (next cycle)
    - Then if cont_en=1: stay in COUNT, counter reset to 0, new window opens on the same tick.
    - If cont_en=0: go to IDLE.
- abort=1 in any state → IDLE on the next edge. Counter cleared. freq, overflow and freq_valid are not updated. abort has priority over tick_1s and start.
- An edge in the closing tick cycle belongs to the closing window. An edge in the opening tick cycle is not counted.
- start while busy: ignored. start and abort together: abort wins.
- cont_en is sampled only at window close.
- freq and overflow hold their values until the next completed window.

## Timing
- Reset values: freq=0, freq_valid=0, overflow=0, busy=0, state=IDLE, counter=0, synchroniser/delay flops=0.
- rst is synchronous and overrides every other input, including mid-window; the window in progress is lost.
- sig_in rising edge to edge=1: SYNC_STAGES+1 clk cycles; with default parameters, counted in the 3rd cycle after it is sampled.
- start to busy=1: 1 cycle.
- Window close tick at cycle T: freq, overflow and freq_valid=1 are visible in cycle T+1. freq_valid is low in T+2.
- Continuous mode: no dead cycles between windows; each window spans exactly the clk cycles from one tick to the next.
- Maximum countable rate: one edge per 2 clk cycles (sig_in high and low each at least one cycle after synchronisation). Faster inputs undercount, and no error is flagged.
- busy falls 1 cycle after the closing tick (cont_en=0) or after abort.

## Test plan
- Basic single-shot: tick every 1000 cycles, sig_in period 10 cycles, start, cont_en=0 → exactly one freq_valid pulse with freq=100, overflow=0, then busy=0.
- Continuous: cont_en=1, tick every 1000 cycles, sig_in period 20, then period 8 after the 3rd window → freq_valid every 1000 cycles; freq=50,50,50,125…; no gap cycles.
- Boundary edge: align a synchronised edge to the closing tick cycle → counted in the closing window (N+1); an edge aligned to the opening tick → not counted.
- Overflow: CNT_W=4, 40 edges in one window → freq=15, overflow=1; the next window with 5 edges → freq=5, overflow=0.
- Abort/start priority: abort mid-COUNT → IDLE next cycle, no freq_valid, freq unchanged. start with abort in the same cycle → stays IDLE. start while busy → no effect.
- Reset mid-window: assert rst during COUNT → all outputs 0 on the next cycle, no freq_valid; a later start behaves as from power-up.
